// File: rtl/rng_share_arbiter.sv
// rng_share_arbiter: round-robin arbiter sharing one Fibonacci LFSR among N_REQ requesters
module rng_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int W = 8,
  parameter logic [W-1:0] TAPS = 8'hB8,
  parameter logic [W-1:0] SEED = 8'h01
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_load,
  input  logic [W-1:0]             cfg_seed,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic                     gnt_valid,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic [W-1:0]             gnt_data,
  output logic [W-1:0]             lfsr_q
);
  localparam int IW = $clog2(N_REQ);
  logic [W-1:0]  lfsr;
  logic [IW-1:0] rr_ptr, win, nxt_ptr;
  logic          found;
  int            j;
  // descending scan so the requester closest to rr_ptr is written last and wins
  always_comb begin
    found = 1'b0;
    win = '0;
    j = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = int'(rr_ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (req[IW'(j)]) begin
        found = 1'b1;
        win = IW'(j);
      end
    end
    nxt_ptr = (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= SEED;
      rr_ptr <= '0;
      gnt <= '0;
      gnt_id <= '0;
      gnt_data <= '0;
    end else begin
      gnt <= '0;
      if (cfg_load) lfsr <= (cfg_seed == '0) ? SEED : cfg_seed;
      else if (lfsr == '0) lfsr <= SEED;
      else if (found) begin
        gnt <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
        gnt_id <= win;
        gnt_data <= lfsr;
        lfsr <= {lfsr[W-2:0], ^(lfsr & TAPS)};
        rr_ptr <= nxt_ptr;
      end
    end
  end
  assign gnt_valid = |gnt;
  assign lfsr_q = lfsr;
endmodule

// File: tb/tb_rng_share_arbiter.sv
// tb_rng_share_arbiter: directed checks of grant order, LFSR values, config load and async reset
module tb_rng_share_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_seed = 8'h00;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic [7:0] gnt_data;
  logic [7:0] lfsr_q;
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] m;
  logic [7:0] first;
  logic [7:0] d1 [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
  bit seen [256];
  int early;
  rng_share_arbiter #(.N_REQ(4), .W(8), .TAPS(8'hB8), .SEED(8'h01)) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_seed(cfg_seed), .req(req),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id), .gnt_data(gnt_data), .lfsr_q(lfsr_q)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
  endtask
  function automatic logic [7:0] adv(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction
  task automatic expect_grant(input string tag, input int id, input logic [7:0] data);
    check({tag, "_gnt"}, 32'(gnt), 32'(1 << id));
    check({tag, "_valid"}, 32'(gnt_valid), 1);
    check({tag, "_id"}, 32'(gnt_id), 32'(id));
    check({tag, "_data"}, 32'(gnt_data), 32'(data));
  endtask
  initial begin
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_valid", 32'(gnt_valid), 0);
    check("rst_id", 32'(gnt_id), 0);
    check("rst_data", 32'(gnt_data), 0);
    check("rst_lfsr", 32'(lfsr_q), 32'h01);
    // single requester: hand-computed LFSR sequence
    req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_grant("t1", 0, d1[i]);
    end
    req = 4'b0000;
    tick();
    check("t1_idle_gnt", 32'(gnt), 0);
    check("t1_idle_data", 32'(gnt_data), 32'h11);
    check("t1_idle_lfsr", 32'(lfsr_q), 32'h23);
    tick();
    check("t1_hold_lfsr", 32'(lfsr_q), 32'h23);
    // all requesting after reset: strict rotation from id 0
    pulse_reset();
    check("t2_rst_lfsr", 32'(lfsr_q), 32'h01);
    m = 8'h01;
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      tick();
      expect_grant("t2", i % 4, m);
      check("t2_distinct", 32'(seen[gnt_data]), 0);
      seen[gnt_data] = 1'b1;
      m = adv(m);
    end
    // rr_ptr is back at 0 here
    req = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_grant("t3a", (i % 2 == 0) ? 1 : 3, m);
      m = adv(m);
    end
    tick();
    expect_grant("t3b_first", 1, m);
    m = adv(m);
    req = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_grant("t3b_only3", 3, m);
      m = adv(m);
    end
    // config load wins over a pending request
    req = 4'b0100;
    cfg_load = 1'b1;
    cfg_seed = 8'h5A;
    tick();
    cfg_load = 1'b0;
    check("t4_load_gnt", 32'(gnt), 0);
    check("t4_load_lfsr", 32'(lfsr_q), 32'h5A);
    tick();
    expect_grant("t4_after", 2, 8'h5A);
    check("t4_adv", 32'(lfsr_q), 32'(adv(8'h5A)));
    req = 4'b0000;
    cfg_load = 1'b1;
    cfg_seed = 8'h00;
    tick();
    cfg_load = 1'b0;
    check("t4_zero_seed", 32'(lfsr_q), 32'h01);
    check("t4_zero_gnt", 32'(gnt), 0);
    // full period from SEED
    m = 8'h01;
    early = 0;
    req = 4'b0001;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (i == 0) first = gnt_data;
      check("t5_nonzero", 32'(gnt_data == 8'h00), 0);
      check("t5_data", 32'(gnt_data), 32'(m));
      if (i > 0 && i < 255 && gnt_data == first) early++;
      m = adv(m);
    end
    check("t5_period", 32'(gnt_data), 32'(first));
    check("t5_no_short_cycle", 32'(early), 0);
    // async reset while grants are flowing
    req = 4'b1111;
    tick();
    tick();
    check("t6_pre_valid", 32'(gnt_valid), 1);
    reset = 1'b1;
    #1;
    check("t6_async_gnt", 32'(gnt), 0);
    check("t6_async_lfsr", 32'(lfsr_q), 32'h01);
    check("t6_async_data", 32'(gnt_data), 0);
    #2;
    reset = 1'b0;
    tick();
    expect_grant("t6_after", 0, 8'h01);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
